// File: rtl/rr_channel_arbiter.sv
// rr_channel_arbiter: merges N_CH request channels into one registered stream, with packet locking and lock timeout
module rr_channel_arbiter #(
    parameter int N_CH    = 64,
    parameter int W_IDX   = 6,
    parameter int W_DATA  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [N_CH-1:0]   req,
    input  logic [W_DATA-1:0] data [N_CH],
    input  logic [N_CH-1:0]   last,
    output logic [N_CH-1:0]   ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_IDX-1:0]  out_idx,
    output logic [W_DATA-1:0] out_data,
    output logic              out_last,
    output logic              err_timeout
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [W_IDX-1:0] LAST_CH = W_IDX'(N_CH - 1);
    localparam logic [W_IDX:0]   NCH     = (W_IDX + 1)'(N_CH);
    localparam logic [15:0]      TO      = 16'(TIMEOUT);

    state_t              state_q, state_d;
    logic [W_IDX-1:0]    lock_q, lock_d, ptr_q, ptr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                valid_q;
    logic [W_IDX-1:0]    idx_q;
    logic [W_DATA-1:0]   data_q;
    logic                last_q;
    logic [N_CH-1:0]     rot;
    logic [W_IDX-1:0]    fp_w, k, rr_w, w, sel;
    logic [W_IDX:0]      sum;
    logic                cap_en, cap;

    function automatic logic [W_IDX-1:0] nxt(input logic [W_IDX-1:0] x);
        return (x == LAST_CH) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search rotates req so that ptr lands at bit 0, then maps back.
    always_comb begin
        rot  = N_CH'({req, req} >> ptr_q);
        fp_w = '0;
        k    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) fp_w = W_IDX'(i);
            if (rot[i]) k = W_IDX'(i);
        end
        sum  = {1'b0, ptr_q} + {1'b0, k};
        rr_w = W_IDX'((sum >= NCH) ? sum - NCH : sum);
        w    = mode ? rr_w : fp_w;
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        cap     = 1'b0;
        cap_en  = !valid_q | out_ready;
        sel     = (state_q == LOCKED) ? lock_q : w;
        if (state_q == IDLE) begin
            if (cap_en && |req) begin
                cap = 1'b1;
                if (last[w]) begin
                    ptr_d = mode ? nxt(w) : ptr_q;
                end else begin
                    state_d = LOCKED;
                    lock_d  = w;
                    cnt_d   = '0;
                end
            end
        end else if (cap_en && req[lock_q]) begin
            cap   = 1'b1;
            cnt_d = '0;
            if (last[lock_q]) begin
                state_d = IDLE;
                ptr_d   = mode ? nxt(lock_q) : ptr_q;
            end
        end else if (cnt_q == TO) begin
            state_d = IDLE;
            err_d   = 1'b1;
            ptr_d   = mode ? nxt(lock_q) : ptr_q;
        end else if (!req[lock_q]) begin
            cnt_d = cnt_q + 16'd1;
        end
        ack = cap ? (N_CH'(1) << sel) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (cap) begin
                valid_q <= 1'b1;
                idx_q   <= sel;
                data_q  <= data[sel];
                last_q  <= last[sel];
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_idx     = idx_q;
    assign out_data    = data_q;
    assign out_last    = last_q;
    assign err_timeout = err_q;
endmodule

// File: doc/rr_channel_arbiter.md
# rr_channel_arbiter

Parametrised multi-channel arbitration controller that merges up to N_CH request channels into one registered output stream with valid/ready flow control. It is the next generation of the per-channel controller: it supports fixed-priority or round-robin selection, locks the grant across multi-beat packets, and releases a stalled lock after a programmable timeout. It sits between the per-channel front-end buffers and the shared downstream pipeline.

## Interface
- N_CH, 64, number of input channels (2..256)
- W_IDX, 6, channel index width; must satisfy 2**W_IDX >= N_CH
- W_DATA, 16, data beat width
- TIMEOUT, 255, idle cycles tolerated on a locked channel before forced release (1..65535)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
- req  input  [0:0] x [N_CH]  per-channel beat available
- data  input  [W_DATA-1:0] x [N_CH]  per-channel beat payload
- last  input  [0:0] x [N_CH]  per-channel end-of-packet marker for the current beat
- ack  output  [0:0] x [N_CH]  combinational; ack[c]=1 means data[c] is captured at this edge
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts the beat when out_valid & out_ready
- out_idx  output  W_IDX  source channel of the held beat
- out_data  output  W_DATA  held beat payload
- out_last  output  1  held beat ends its packet
- err_timeout  output  1  one-cycle pulse when a lock is force-released

## Operation
- Capture enable: cap_en = !out_valid | out_ready. No beat is captured when cap_en=0; ack is all-zero.
- States: IDLE (no lock) and LOCKED (grant pinned to lock_ch).
- IDLE: if cap_en and any req, select winner w. mode=0: lowest index c with req[c]. mode=1: first c with req[c] searching ptr, ptr+1, ..., wrapping at N_CH-1 -> 0. ack[w]=1; capture data[w], last[w], w.
  - last[w]=1: stay IDLE; if mode=1, ptr <= (w+1) mod N_CH.
  - last[w]=0: go LOCKED, lock_ch <= w.
- LOCKED: only lock_ch may be acknowledged; other req are ignored. If cap_en & req[lock_ch]: ack[lock_ch]=1, capture; if last[lock_ch]=1 go IDLE and (mode=1) ptr <= (lock_ch+1) mod N_CH.
- Timeout counter: cleared on entry to LOCKED and on every captured beat; increments in LOCKED while req[lock_ch]=0 (cap_en irrelevant; downstream back-pressure never times out). When the count reaches TIMEOUT: go IDLE, pulse err_timeout, ptr <= (lock_ch+1) mod N_CH in mode=1 and unchanged in mode=0. out_last of already captured beats is not altered.
- mode is sampled only in IDLE arbitration; a change during LOCKED takes effect at the next IDLE decision. ptr is maintained only when mode=1 and is retained across mode changes.
- Output register: on capture, out_valid<=1 and out_idx/out_data/out_last load. On out_valid & out_ready without capture, out_valid<=0; out_idx/out_data/out_last hold their values.
- Simultaneous drain and capture in the same cycle: the new beat replaces the old one and out_valid stays 1.
- Reset values: out_valid=0, out_idx=0, out_data=0, out_last=0, err_timeout=0, ack=0, state=IDLE, ptr=0, timeout count=0. Reset asserted mid-packet abandons the lock and drops the held beat immediately.

## Timing
- req[c] to out_valid: 1 cycle (ack in cycle N, out_valid high in N+1).
- Throughput: 1 beat/cycle with out_ready held high, including back-to-back packets from different channels with no bubble.
- ack is combinational from req, last, mode, state, ptr, out_valid and out_ready. There is no combinational path from data to any output.
- err_timeout is asserted in the cycle after the count reaches TIMEOUT, coincident with the return to IDLE.

## Test plan
- Reset then mode=1, req[3]=req[10]=1, last=1 on both, out_ready=1 -> out_idx 3 at cycle 1 and 10 at cycle 2, ptr=11; after reset all outputs read 0.
- mode=0, req[5]=req[2]=1 continuously, last=1 -> every beat has out_idx=2; channel 5 is never acknowledged.
- mode=1, channel 7 sends 4-beat packet (last on beat 4) while req[1]=1 -> four beats with out_idx=7 contiguous, then out_idx=1.
- out_ready=0 for 5 cycles with req[0]=1 -> one beat held, ack[0]=0 for 5 cycles, out_data stable; on release, 1 beat/cycle resumes.
- TIMEOUT=8, channel 4 locked after 1 beat (last=0) then req[4]=0 -> err_timeout pulses once 9 cycles after the last capture; req[6] is acknowledged the following cycle.
- Reset asserted mid-packet on channel 9 -> out_valid=0 on the next sample with no clock edge required; after release, channel 2 wins immediately with ptr=0.
